// File: rtl/uart_frame_driver.sv
// UART stimulus source: valid/ready byte FIFO feeding a start/data/parity/stop serialiser.
// Define UART_FRAME_DRIVER_PARITY_EN to build the optional parity bit.
module uart_frame_driver #(
  parameter int UART_DATA_SIZE = 8,
  parameter int CLKS_PER_BIT   = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [UART_DATA_SIZE-1:0]     i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_two_stop,
  input  logic [1:0]                    i_parity_mode,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_SIZE + 1);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_SIZE - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_FRAME_DRIVER_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  logic [UART_DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [AW:0]               count_q, count_d;
  logic                      push, pop;
  logic [UART_DATA_SIZE-1:0] head;

  state_e                    state_q;
  logic [CW-1:0]             clk_cnt_q;
  logic [BW-1:0]             bit_idx_q;
  logic [UART_DATA_SIZE-1:0] shift_q;
  logic                      two_stop_q;
  logic                      stop_cnt_q;
  logic                      tx_q;
  logic                      bit_end, last_stop;

`ifdef UART_FRAME_DRIVER_PARITY_EN
  logic par_en_q, par_bit_q;
`else
  logic unused_parity;
  assign unused_parity = ^i_parity_mode;
`endif

  assign o_ready      = (count_q != FULL);
  assign o_fifo_count = count_q;
  assign o_tx         = tx_q;
  assign o_busy       = (state_q != IDLE);
  assign push         = i_valid && o_ready;
  assign head         = mem_q[rd_ptr_q];
  assign bit_end      = (clk_cnt_q == CLK_LAST);
  assign last_stop    = (stop_cnt_q == two_stop_q);

  // Pops happen only where a new frame begins: from IDLE or at the last stop cycle.
  always_comb begin
    pop = 1'b0;
    if (count_q != '0) begin
      if (state_q == IDLE)
        pop = 1'b1;
      else if (state_q == STOP && bit_end && last_stop)
        pop = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (push)
      mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
`ifdef UART_FRAME_DRIVER_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      if (state_q == IDLE || bit_end)
        clk_cnt_q <= '0;
      else
        clk_cnt_q <= clk_cnt_q + 1'b1;
      // Frame config is captured only here, so mid-frame changes are ignored.
      if (pop) begin
        shift_q    <= head;
        two_stop_q <= i_two_stop;
`ifdef UART_FRAME_DRIVER_PARITY_EN
        par_en_q   <= ^i_parity_mode;
        par_bit_q  <= (^head) ^ i_parity_mode[1];
`endif
      end
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == BIT_LAST) begin
`ifdef UART_FRAME_DRIVER_PARITY_EN
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q    <= STOP;
                tx_q       <= 1'b1;
                stop_cnt_q <= 1'b0;
              end
`else
              state_q    <= STOP;
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end
        end
`ifdef UART_FRAME_DRIVER_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q    <= STOP;
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              stop_cnt_q <= 1'b1;
            end else if (pop) begin
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
